// File: rtl/spi_trig_ctrl_if.sv
// spi_trig_ctrl_if: groups the config bus, the arm/disarm controls, the SPI receiver
// handshake and the trigger status outputs of spi_trig_ctrl.
//   master : the driver side (config host, arm/disarm source, SPI receiver events)
//   slave  : the trigger controller itself
//   cfg_wr/cfg_addr/cfg_data : config register write port
//   arm/disarm               : state control pulses
//   frm_done/SPItrig         : per-frame events from the SPI receiver
//   edg/len8/mask/match      : receiver configuration driven from the config registers
//   armed/triggered/trig     : state decodes and trigger pulse
//   hit_cnt                  : matching frames since the last arm
interface spi_trig_ctrl_if;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        arm;
    logic        disarm;
    logic        frm_done;
    logic        SPItrig;
    logic        edg;
    logic        len8;
    logic [15:0] mask;
    logic [15:0] match;
    logic        armed;
    logic        triggered;
    logic        trig;
    logic [7:0]  hit_cnt;

    modport master (
        output cfg_wr, cfg_addr, cfg_data, arm, disarm, frm_done, SPItrig,
        input  edg, len8, mask, match, armed, triggered, trig, hit_cnt
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, arm, disarm, frm_done, SPItrig,
        output edg, len8, mask, match, armed, triggered, trig, hit_cnt
    );
endinterface

// File: rtl/spi_trig_ctrl.sv
// spi_trig_ctrl: config registers and trigger state machine for an SPI frame matcher.
// Counts matching frames while armed and enters TRIG once the count reaches the
// programmed threshold, emitting a one-cycle trig pulse.
//   clk : system clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : spi_trig_ctrl_if slave modport (config bus, controls, receiver events, status)
module spi_trig_ctrl (
    input  logic           clk,
    input  logic           rst,
    spi_trig_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StTrig} state_e;

    state_e      state_q, state_d;
    logic [15:0] match_q, mask_q, ctrl_q;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic        trig_q, trig_d;

    logic        consec;
    logic [7:0]  thresh, eff_thresh;
    logic [8:0]  inc_sum;
    logic        reach;
    logic        hit, miss;
    logic        cfg_we;
    logic        unused_ctrl;

    assign consec      = ctrl_q[2];
    assign thresh      = ctrl_q[15:8];
    assign unused_ctrl = ^ctrl_q[7:3];
    // A zero threshold behaves as one so the first hit triggers.
    assign eff_thresh  = (thresh == 8'd0) ? 8'd1 : thresh;
    assign inc_sum     = {1'b0, hit_cnt_q} + 9'd1;
    assign reach       = (inc_sum >= {1'b0, eff_thresh});

    assign hit  = bus.SPItrig;
    assign miss = bus.frm_done & ~bus.SPItrig;

    // Config is frozen while armed so the receiver compare cannot change mid-search.
    assign cfg_we = bus.cfg_wr && (state_q != StArmed) && (bus.cfg_addr != 2'd3);

    always_comb begin
        state_d   = state_q;
        hit_cnt_d = hit_cnt_q;
        trig_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!bus.disarm && bus.arm) begin
                    state_d   = StArmed;
                    hit_cnt_d = 8'd0;
                end
            end
            StArmed: begin
                if (bus.disarm) begin
                    state_d = StIdle;
                end else if (hit) begin
                    hit_cnt_d = (hit_cnt_q == 8'hFF) ? 8'hFF : inc_sum[7:0];
                    if (reach) begin
                        state_d = StTrig;
                        trig_d  = 1'b1;
                    end
                end else if (miss && consec) begin
                    hit_cnt_d = 8'd0;
                end
            end
            StTrig: begin
                if (bus.disarm) begin
                    state_d = StIdle;
                end else if (bus.arm) begin
                    state_d   = StArmed;
                    hit_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            match_q   <= 16'd0;
            mask_q    <= 16'd0;
            ctrl_q    <= 16'd0;
            hit_cnt_q <= 8'd0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_cnt_q <= hit_cnt_d;
            trig_q    <= trig_d;
            if (cfg_we) begin
                case (bus.cfg_addr)
                    2'd0:    match_q <= bus.cfg_data;
                    2'd1:    mask_q  <= bus.cfg_data;
                    2'd2:    ctrl_q  <= bus.cfg_data;
                    default: ;
                endcase
            end
        end
    end

    assign bus.edg       = ctrl_q[0];
    assign bus.len8      = ctrl_q[1];
    assign bus.mask      = mask_q;
    assign bus.match     = match_q;
    assign bus.armed     = (state_q == StArmed);
    assign bus.triggered = (state_q == StTrig);
    assign bus.trig      = trig_q;
    assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_spi_trig_ctrl.sv
// tb_spi_trig_ctrl: directed scoreboard bench for spi_trig_ctrl. Each cycle's expected
// status is pushed when its stimulus is driven and popped after the clock edge.
module tb_spi_trig_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    typedef struct {
        string      tag;
        logic       armed;
        logic       triggered;
        logic       trig;
        logic [7:0] hit_cnt;
    } exp_t;

    exp_t sb_q[$];

    spi_trig_ctrl_if bus ();

    spi_trig_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle with the given input pulses; expected status after the edge.
    task automatic cyc(input string tag, input logic a, input logic d, input logic f,
                       input logic s, input logic r, input logic e_arm, input logic e_trg,
                       input logic e_pulse, input logic [7:0] e_cnt);
        exp_t e;
        bus.arm      = a;
        bus.disarm   = d;
        bus.frm_done = f;
        bus.SPItrig  = s;
        rst          = r;
        e.tag = tag; e.armed = e_arm; e.triggered = e_trg; e.trig = e_pulse; e.hit_cnt = e_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.frm_done = 1'b0; bus.SPItrig = 1'b0;
        rst = 1'b0;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, ".armed"},     {15'd0, bus.armed},     {15'd0, e.armed});
            check_val({e.tag, ".triggered"}, {15'd0, bus.triggered}, {15'd0, e.triggered});
            check_val({e.tag, ".trig"},      {15'd0, bus.trig},      {15'd0, e.trig});
            check_val({e.tag, ".hit_cnt"},   {8'd0, bus.hit_cnt},    {8'd0, e.hit_cnt});
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_wr   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        @(posedge clk);
        #1;
        bus.cfg_wr = 1'b0;
    endtask

    task automatic check_cfg(input string tag, input logic [15:0] e_match,
                             input logic [15:0] e_mask, input logic e_edg, input logic e_len8);
        check_val({tag, ".match"}, bus.match, e_match);
        check_val({tag, ".mask"},  bus.mask,  e_mask);
        check_val({tag, ".edg"},   {15'd0, bus.edg},  {15'd0, e_edg});
        check_val({tag, ".len8"},  {15'd0, bus.len8}, {15'd0, e_len8});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = 16'd0;
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.frm_done = 1'b0; bus.SPItrig = 1'b0;
        @(posedge clk);
        #1;
        // Reset overrides arm and a config write in the same cycle.
        bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 16'hFFFF;
        cyc("rst", 1, 0, 0, 0, 1, 0, 0, 0, 8'd0);
        bus.cfg_wr = 1'b0;
        check_cfg("rst_cfg", 16'h0000, 16'h0000, 0, 0);

        // Config writes in IDLE; address 3 is dropped.
        wr(2'd0, 16'hA5C3);
        wr(2'd1, 16'h00FF);
        wr(2'd2, 16'h0303);
        wr(2'd3, 16'hFFFF);
        check_cfg("cfg", 16'hA5C3, 16'h00FF, 1, 1);

        // thresh=3, consec=0: hits separated by misses.
        cyc("arm1",  1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("hit1",  0, 0, 0, 1, 0, 1, 0, 0, 8'd1);
        cyc("miss1", 0, 0, 1, 0, 0, 1, 0, 0, 8'd1);
        cyc("hit2",  0, 0, 1, 1, 0, 1, 0, 0, 8'd2);
        cyc("miss2", 0, 0, 1, 0, 0, 1, 0, 0, 8'd2);
        cyc("hit3",  0, 0, 1, 1, 0, 0, 1, 1, 8'd3);
        cyc("trig_hold", 0, 0, 0, 0, 0, 0, 1, 0, 8'd3);
        cyc("trig_ign",  0, 0, 1, 1, 0, 0, 1, 0, 8'd3);

        // Re-arm from TRIG, then write lockout while armed.
        cyc("rearm", 1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        wr(2'd0, 16'h1234);
        check_val("lock.match", bus.match, 16'hA5C3);
        cyc("disarm1", 0, 1, 0, 0, 0, 0, 0, 0, 8'd0);
        wr(2'd0, 16'h1234);
        check_val("unlock.match", bus.match, 16'h1234);

        // thresh=2, consec=1.
        wr(2'd2, 16'h0204);
        check_cfg("cfg2", 16'h1234, 16'h00FF, 0, 0);
        cyc("arm2",  1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("c_hit", 0, 0, 1, 1, 0, 1, 0, 0, 8'd1);
        cyc("c_miss", 0, 0, 1, 0, 0, 1, 0, 0, 8'd0);
        cyc("c_hit2", 0, 0, 0, 1, 0, 1, 0, 0, 8'd1);
        cyc("c_hit3", 0, 0, 1, 1, 0, 0, 1, 1, 8'd2);

        // Conflicts: disarm holds count; arm+disarm in IDLE stays IDLE.
        cyc("disarm2", 0, 1, 0, 0, 0, 0, 0, 0, 8'd2);
        cyc("arm_dis", 1, 1, 0, 0, 0, 0, 0, 0, 8'd2);
        cyc("idle_ign", 0, 0, 1, 1, 0, 0, 0, 0, 8'd2);

        // thresh=0 acts as 1; disarm beats the threshold-reaching hit.
        wr(2'd2, 16'h0000);
        cyc("arm3",    1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("hit_dis", 0, 1, 1, 1, 0, 0, 0, 0, 8'd0);
        cyc("after_dis", 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc("arm4",    1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        cyc("t0_hit",  0, 0, 0, 1, 0, 0, 1, 1, 8'd1);

        // Reset while armed with hit_cnt=5.
        cyc("disarm3", 0, 1, 0, 0, 0, 0, 0, 0, 8'd1);
        wr(2'd1, 16'hBEEF);
        wr(2'd2, 16'h0A03);
        cyc("arm5", 1, 0, 0, 0, 0, 1, 0, 0, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc($sformatf("r_hit%0d", i), 0, 0, 1, 1, 0, 1, 0, 0, i[7:0]);
        end
        cyc("rst_mid", 0, 0, 1, 1, 1, 0, 0, 0, 8'd0);
        check_cfg("rst_mid_cfg", 16'h0000, 16'h0000, 0, 0);
        cyc("post_rst", 0, 0, 1, 1, 0, 0, 0, 0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
